// File: rtl/nanocalc_seq.sv
// Command sequencer for the 4-bit nanocalc ALU: registers operands into the ALU,
// waits SETTLE_CYCLES, captures the result into an accumulator and a response channel.
module nanocalc_seq #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_use_acc,
  input  logic       cmd_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [3:0] acc,
  output logic [7:0] op_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt;
  logic       accept, capture;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_n = cmd_clr ? RESP : DRIVE;
      end
      DRIVE: if (cnt == 4'd0) begin
        capture = 1'b1;
        state_n = RESP;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_op     <= 3'd0;
      rsp_result <= 4'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      acc        <= 4'd0;
      op_count   <= 8'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (cmd_clr) begin
          // clear is a pure accumulator reset answered immediately; ALU regs untouched
          acc        <= 4'd0;
          rsp_result <= 4'd0;
          rsp_carry  <= 1'b0;
          rsp_zero   <= 1'b1;
        end else begin
          alu_a  <= cmd_use_acc ? acc : cmd_a;
          alu_b  <= cmd_b;
          alu_op <= cmd_op;
          cnt    <= CNT_INIT;
        end
      end
      if (state == DRIVE && !capture) cnt <= cnt - 4'd1;
      if (capture) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        acc        <= alu_result;
        if (op_count != 8'hFF) op_count <= op_count + 8'd1;
      end
    end
  end

  assign cmd_ready = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_nanocalc_seq.sv
// Directed bench for nanocalc_seq: two instances (settle 1 and 4) each driving
// a behavioural 4-bit ALU model, with hand-computed expected responses.
module tb_nanocalc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // ALU behaviour: {carry, zero, result}
  function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] w;
    w = '0;
    case (op)
      3'd0: w = {1'b0, a} + {1'b0, b};
      3'd1: w = {1'b0, a} - {1'b0, b};
      3'd2: w = {1'b0, a & b};
      3'd3: w = {1'b0, a | b};
      3'd4: w = {1'b0, a ^ b};
      3'd5: w = {1'b0, ~a};
      3'd6: w = {a, 1'b0};
      default: w = (a == b) ? 5'b10001 : 5'b00000;
    endcase
    return {w[4], w[3:0] == 4'd0, w[3:0]};
  endfunction

  // settle-1 instance
  logic       rst, cmd_valid, cmd_ready, cmd_use_acc, cmd_clr;
  logic [2:0] cmd_op, alu_op;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result, acc;
  logic       alu_carry, alu_zero, rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
  logic [7:0] op_count;

  assign {alu_carry, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

  nanocalc_seq #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_clr(cmd_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc(acc), .op_count(op_count), .busy(busy)
  );

  // settle-4 instance
  logic       rst4, cmd_valid4, cmd_ready4, cmd_use_acc4, cmd_clr4;
  logic [2:0] cmd_op4, alu_op4;
  logic [3:0] cmd_a4, cmd_b4, alu_a4, alu_b4, alu_result4, rsp_result4, acc4;
  logic       alu_carry4, alu_zero4, rsp_valid4, rsp_ready4, rsp_carry4, rsp_zero4, busy4;
  logic [7:0] op_count4;

  assign {alu_carry4, alu_zero4, alu_result4} = alu_f(alu_op4, alu_a4, alu_b4);

  nanocalc_seq #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst4), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op4), .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_use_acc(cmd_use_acc4), .cmd_clr(cmd_clr4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
    .alu_result(alu_result4), .alu_carry(alu_carry4), .alu_zero(alu_zero4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_carry(rsp_carry4), .rsp_zero(rsp_zero4), .acc(acc4), .op_count(op_count4), .busy(busy4)
  );

  // Issue one command on the settle-1 instance; returns cycles from accept edge to rsp_valid.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ua, input logic cl, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_clr = cl; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, exp_cnt;
    logic seen;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_use_acc = 0; cmd_clr = 0; rsp_ready = 0;
    rst4 = 1; cmd_valid4 = 0; cmd_op4 = 0; cmd_a4 = 0; cmd_b4 = 0; cmd_use_acc4 = 0; cmd_clr4 = 0; rsp_ready4 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outs", {alu_a, alu_b, alu_op, rsp_result, rsp_carry, rsp_zero, acc, op_count}, 0);
    rst = 0; rst4 = 0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // add 9+8
    run_cmd(3'd0, 4'd9, 4'd8, 1'b0, 1'b0, lat);
    chk("add_lat", lat, 2);
    chk("add_res", {rsp_carry, rsp_zero, rsp_result}, {1'b1, 1'b0, 4'd1});
    chk("add_acc", acc, 1);
    chk("add_cnt", op_count, 1);
    take_rsp();
    chk("add_ready_after", cmd_ready, 1);
    chk("alu_hold", {alu_op, alu_a, alu_b}, {3'd0, 4'd9, 4'd8});

    // chain: clr, acc+3, acc-5
    run_cmd(3'd3, 4'd6, 4'd6, 1'b1, 1'b1, lat);
    chk("clr_lat", lat, 1);
    chk("clr_res", {rsp_carry, rsp_zero, rsp_result}, {1'b0, 1'b1, 4'd0});
    chk("clr_acc", acc, 0);
    chk("clr_cnt", op_count, 1);
    chk("clr_alu_hold", {alu_op, alu_a, alu_b}, {3'd0, 4'd9, 4'd8});
    take_rsp();
    run_cmd(3'd0, 4'd15, 4'd3, 1'b1, 1'b0, lat);
    chk("chain_add_alu_a", alu_a, 0);
    chk("chain_add_res", {rsp_carry, rsp_zero, rsp_result}, {1'b0, 1'b0, 4'd3});
    take_rsp();
    run_cmd(3'd1, 4'd0, 4'd5, 1'b1, 1'b0, lat);
    chk("chain_sub_res", {rsp_carry, rsp_zero, rsp_result}, {1'b1, 1'b0, 4'd14});
    chk("chain_acc", acc, 14);
    chk("chain_cnt", op_count, 3);
    take_rsp();

    // equality and zero
    run_cmd(3'd7, 4'd7, 4'd7, 1'b0, 1'b0, lat);
    chk("eq_res", {rsp_carry, rsp_zero, rsp_result}, {1'b1, 1'b0, 4'd1});
    chk("eq_acc", acc, 1);
    take_rsp();
    run_cmd(3'd4, 4'd5, 4'd5, 1'b0, 1'b0, lat);
    chk("xor_res", {rsp_carry, rsp_zero, rsp_result}, {1'b0, 1'b1, 4'd0});
    chk("xor_acc", acc, 0);
    take_rsp();

    // backpressure with cmd_* churning while not ready
    run_cmd(3'd6, 4'd9, 4'd0, 1'b0, 1'b0, lat);
    cmd_valid = 1; cmd_clr = 1; cmd_a = 4'd3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", {rsp_valid, rsp_carry, rsp_zero, rsp_result}, {1'b1, 1'b1, 1'b0, 4'd2});
      chk("bp_ready_busy", {cmd_ready, busy}, 2'b01);
      cmd_op = 3'(i); cmd_b = 4'(i);
      @(posedge clk); #1;
    end
    chk("bp_alu_hold", {alu_op, alu_a}, {3'd6, 4'd9});
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0; cmd_valid = 0; cmd_clr = 0;
    chk("bp_release", {cmd_ready, rsp_valid, busy}, 3'b100);
    chk("bp_acc_cnt", {acc, op_count}, {4'd2, 8'd6});

    // settle-4: latency, then reset mid-DRIVE
    cmd_op4 = 3'd0; cmd_a4 = 4'd3; cmd_b4 = 4'd4; cmd_valid4 = 1;
    @(posedge clk); #1;
    cmd_valid4 = 0;
    lat = 1;
    while (!rsp_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("s4_lat", lat, 5);
    chk("s4_res", rsp_result4, 7);
    @(posedge clk); #1;
    chk("s4_acc_cnt", {acc4, op_count4, cmd_ready4}, {4'd7, 8'd1, 1'b1});
    cmd_a4 = 4'd1; cmd_b4 = 4'd1; cmd_valid4 = 1;
    @(posedge clk); #1;
    cmd_valid4 = 0;
    @(posedge clk); #1;
    rst4 = 1;
    #1;
    chk("s4_rst_ready_low", {cmd_ready4, busy4}, 2'b01);
    @(posedge clk); #1;
    rst4 = 0;
    #1;
    chk("s4_after_rst", {busy4, acc4, op_count4, cmd_ready4, alu_a4}, {1'b0, 4'd0, 8'd0, 1'b1, 4'd0});
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid4;
    end
    chk("s4_no_rsp", seen, 0);

    // saturation
    exp_cnt = 6;
    for (int i = 0; i < 255; i++) begin
      run_cmd(3'd0, 4'd1, 4'd1, 1'b0, 1'b0, lat);
      exp_cnt++;
      take_rsp();
    end
    chk("sat_cnt", op_count, (exp_cnt > 255) ? 255 : exp_cnt);
    chk("sat_acc", acc, 2);
    run_cmd(3'd0, 4'd0, 4'd0, 1'b0, 1'b1, lat);
    take_rsp();
    chk("sat_after_clr", {op_count, acc}, {8'd255, 4'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
